keypad4x4_scan: RTL
===================

// Module: keypad4x4_scan
// PURPOSE
//  Scanner for the 4x4 matrix keypad on the expansion board: the input side of the board's multiplexed I/O.
//  Drives one keypad row low at a time and samples the columns.
//  Debounces over whole scans and outputs a one-cycle key event plus a 16-bit history of the last four codes.
//  o_key_hist connects directly to the 4-digit seven-segment driver's 16-bit data input.
// PARAMETERS
//  DIV_W      11  prescaler width; scan tick every 2**DIV_W i_clk cycles (same rate as display digit scan)
//  DEB_SCANS  4   consecutive identical full-scan results required to accept a press or a release (>=1)
// PORTS
//  i_clk        in   1   system clock
//  i_rst        in   1   reset, asynchronous, active-high
//  i_col        in   4   column sense, active-low (pulled up), asynchronous to i_clk
//  o_row        out  4   row drive, active-low one-hot, registered
//  o_key_code   out  4   code of last accepted key = row*4 + col
//  o_key_valid  out  1   one-i_clk pulse when a press is accepted
//  o_key_down   out  1   level; 1 while accepted key is held (until release is debounced)
//  o_key_hist   out  16  last four accepted codes; newest in [3:0]
// BEHAVIOUR
//  Reset values: o_row=4'b1110, o_key_code=0, o_key_valid=0, o_key_down=0, o_key_hist=0.
//    Reset also sets FSM=IDLE, prescaler=0, row pointer=0, sync flops=4'hF.
//  i_col passes through a 2-FF synchronizer before any use.
//  Prescaler: free-running DIV_W-bit counter. tick = 1 for one cycle when the counter is all-ones.
//  On tick:
//    - Sample the synced columns for the current row.
//    - Then advance the row pointer (3 wraps to 0) and register o_row = ~(1<<ptr).
//    - Each row is therefore settled for 2**DIV_W-2 cycles before it is sampled.
//  Per-scan accumulator (cleared at the start of row 0):
//    - Row with exactly one low column: records hit, code = {row[1:0], col_idx[1:0]}.
//    - More than one low column in a row, or hits in more than one row: scan result = MULTI.
//    - The sample of row 3 closes the scan. Result is NONE, KEY(code) or MULTI; MULTI is treated as NONE.
//  Debounce FSM; acts only on scan-complete; 3-bit match counter:
//    IDLE:  KEY(c) -> PRESS_WAIT, cand=c, cnt=1. If DEB_SCANS==1, accept immediately instead.
//    PRESS_WAIT:
//      KEY(cand) -> cnt++; on reaching DEB_SCANS: accept, go to HELD.
//      KEY(other) -> cand=other, cnt=1.
//      NONE -> IDLE.
//    accept:
//      - o_key_code <= cand; o_key_hist <= {hist[11:0], cand}.
//      - o_key_valid=1 for exactly the next i_clk cycle; o_key_down <= 1.
//      - Latency: valid is high in the cycle after the tick that closes the DEB_SCANS-th matching scan.
//    HELD:
//      NONE -> RELEASE_WAIT, cnt=1. If DEB_SCANS==1, go straight to IDLE.
//      Any KEY -> stay. No auto-repeat; a second key is not registered until release.
//    RELEASE_WAIT:
//      NONE -> cnt++; on reaching DEB_SCANS: IDLE, o_key_down <= 0.
//      KEY -> HELD, o_key_down stays 1.
//  Multiple keys pressed (ghosting) never produce o_key_valid.
//  Reset mid-scan or mid-hold:
//    - All state returns to reset values immediately (async); a pending press is discarded.
//    - After release of reset, a fresh DEB_SCANS debounce is required even if the key is still held.
//  Key legend mapping (code -> printed symbol) is outside this block.
// STRUCTURE
//  Shared include keypad_defs.vh: FSM state encodings (IDLE/PRESS_WAIT/HELD/RELEASE_WAIT),
//    scan-result encodings (NONE/KEY/MULTI), ROWS=4, COLS=4.
//  One sub-module: keypad_debounce. Contains the FSM, match counter, and code/hist/valid/down registers.
//    Interface: scan_done, scan_key, scan_code.
//  The top holds the prescaler, row driver, synchronizer and scan accumulator.
// TESTING (sim with DIV_W=3, DEB_SCANS=4; model a keypad matrix pulling i_col low for the driven row)
//  1. Reset -> o_row=1110, outputs 0. After release, o_row cycles 1110,1101,1011,0111 every 8 clocks.
//  2. Press row1/col2 for 6 scans, then release for 5 scans:
//       - exactly one o_key_valid with code 6; o_key_down=1;
//       - o_key_down falls after the 4th empty scan; hist=16'h0006.
//  3. Bounce: press key 5 for 2 scans, release 1 scan, repeat 3 times -> no o_key_valid, o_key_down stays 0.
//  4. Press keys 0 and 15 together for 8 scans -> no o_key_valid (MULTI); hist unchanged.
//  5. Debounced presses of codes 1,2,3,15 in sequence -> four pulses; hist=16'h123F, o_key_code=4'hF.
//  6. Assert i_rst while HELD with key 9 still pressed:
//       - outputs reset immediately;
//       - after release of reset, o_key_valid re-fires with code 9 only after 4 full scans.

Source files
------------

// File: rtl/keypad4x4_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: debounce states, scan results,
// matrix geometry and column decode.
package keypad4x4_scan_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } deb_state_e;

    typedef enum logic [1:0] {
        ResNone,
        ResKey,
        ResMulti
    } scan_res_e;

    function automatic logic f_one_hot(input logic [COLS-1:0] i_v);
        return (i_v != '0) && ((i_v & (i_v - 1'b1)) == '0);
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [1:0] f_col_idx(input logic [COLS-1:0] i_low);
        logic [1:0] v_idx;
        v_idx = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (i_low[i]) v_idx = 2'(i);
        end
        return v_idx;
    endfunction

endpackage

// File: rtl/keypad4x4_scan_debounce.sv
// Whole-scan debounce FSM for the keypad: accepts a press or release only after DEB_SCANS
// consecutive identical scan results, and holds the code/history/valid/down outputs.
module keypad4x4_scan_debounce
    import keypad4x4_scan_pkg::*;
#(
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_scan_done,
    input  logic        i_scan_key,
    input  logic [3:0]  i_scan_code,
    output logic [3:0]  o_key_code,
    output logic        o_key_valid,
    output logic        o_key_down,
    output logic [15:0] o_key_hist
);

    localparam logic [2:0] DebTarget = 3'(DEB_SCANS);

    deb_state_e r_state;
    logic [2:0] r_cnt;
    logic [3:0] r_cand;
    logic [2:0] w_cnt_inc;
    logic       w_reach;

    assign w_cnt_inc = r_cnt + 3'd1;
    assign w_reach   = (w_cnt_inc == DebTarget);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_cand      <= 4'd0;
            o_key_code  <= 4'd0;
            o_key_valid <= 1'b0;
            o_key_down  <= 1'b0;
            o_key_hist  <= 16'd0;
        end else begin
            o_key_valid <= 1'b0;
            if (i_scan_done) begin
                unique case (r_state)
                    StIdle: begin
                        if (i_scan_key) begin
                            r_cand <= i_scan_code;
                            r_cnt  <= 3'd1;
                            if (DebTarget == 3'd1) begin
                                o_key_code  <= i_scan_code;
                                o_key_hist  <= {o_key_hist[11:0], i_scan_code};
                                o_key_valid <= 1'b1;
                                o_key_down  <= 1'b1;
                                r_state     <= StHeld;
                            end else begin
                                r_state <= StPressWait;
                            end
                        end
                    end
                    StPressWait: begin
                        if (!i_scan_key) begin
                            r_state <= StIdle;
                        end else if (i_scan_code == r_cand) begin
                            r_cnt <= w_cnt_inc;
                            if (w_reach) begin
                                o_key_code  <= r_cand;
                                o_key_hist  <= {o_key_hist[11:0], r_cand};
                                o_key_valid <= 1'b1;
                                o_key_down  <= 1'b1;
                                r_state     <= StHeld;
                            end
                        end else begin
                            r_cand <= i_scan_code;
                            r_cnt  <= 3'd1;
                        end
                    end
                    // No auto-repeat: any key while held just keeps the hold alive.
                    StHeld: begin
                        if (!i_scan_key) begin
                            if (DebTarget == 3'd1) begin
                                o_key_down <= 1'b0;
                                r_state    <= StIdle;
                            end else begin
                                r_cnt   <= 3'd1;
                                r_state <= StReleaseWait;
                            end
                        end
                    end
                    StReleaseWait: begin
                        if (i_scan_key) begin
                            r_state <= StHeld;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_reach) begin
                                o_key_down <= 1'b0;
                                r_state    <= StIdle;
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad4x4_scan.sv
// 4x4 matrix keypad scanner: prescaled row drive, column synchronizer and per-scan hit
// accumulator feeding the whole-scan debounce block.
module keypad4x4_scan
    import keypad4x4_scan_pkg::*;
#(
    parameter int unsigned DIV_W     = 11,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_col,
    output logic [3:0]  o_row,
    output logic [3:0]  o_key_code,
    output logic        o_key_valid,
    output logic        o_key_down,
    output logic [15:0] o_key_hist
);

    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       r_ptr;
    logic             r_acc_hit;
    logic             r_acc_multi;
    logic [3:0]       r_acc_code;

    logic       w_tick;
    logic [1:0] w_ptr_nxt;
    logic [3:0] w_low;
    logic       w_one;
    logic       w_many;
    logic       w_base_hit;
    logic       w_base_multi;
    logic [3:0] w_base_code;
    logic       w_nxt_hit;
    logic       w_nxt_multi;
    logic [3:0] w_nxt_code;
    logic       w_scan_done;
    logic       w_scan_key;
    scan_res_e  w_scan_res;

    assign w_tick    = &r_div;
    assign w_ptr_nxt = r_ptr + 2'd1;
    assign w_low     = ~r_sync2;
    assign w_one     = f_one_hot(w_low);
    assign w_many    = (w_low != 4'd0) && !w_one;

    // Row 0 starts a fresh scan, so it ignores whatever the previous scan left behind.
    assign w_base_hit   = (r_ptr == 2'd0) ? 1'b0 : r_acc_hit;
    assign w_base_multi = (r_ptr == 2'd0) ? 1'b0 : r_acc_multi;
    assign w_base_code  = (r_ptr == 2'd0) ? 4'd0 : r_acc_code;

    assign w_nxt_hit   = w_base_hit | w_one;
    assign w_nxt_multi = w_base_multi | w_many | (w_one & w_base_hit);
    assign w_nxt_code  = w_one ? {r_ptr, f_col_idx(w_low)} : w_base_code;
    assign w_scan_done = w_tick && (r_ptr == 2'(ROWS - 1));

    always_comb begin
        w_scan_res = ResNone;
        if (w_nxt_multi) begin
            w_scan_res = ResMulti;
        end else if (w_nxt_hit) begin
            w_scan_res = ResKey;
        end
    end

    assign w_scan_key = (w_scan_res == ResKey);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div       <= '0;
            r_sync1     <= 4'hF;
            r_sync2     <= 4'hF;
            r_ptr       <= 2'd0;
            o_row       <= 4'b1110;
            r_acc_hit   <= 1'b0;
            r_acc_multi <= 1'b0;
            r_acc_code  <= 4'd0;
        end else begin
            r_div   <= r_div + DIV_W'(1);
            r_sync1 <= i_col;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_acc_hit   <= w_nxt_hit;
                r_acc_multi <= w_nxt_multi;
                r_acc_code  <= w_nxt_code;
                r_ptr       <= w_ptr_nxt;
                o_row       <= ~(4'b0001 << w_ptr_nxt);
            end
        end
    end

    keypad4x4_scan_debounce #(
        .DEB_SCANS (DEB_SCANS)
    ) u_debounce (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_scan_done (w_scan_done),
        .i_scan_key  (w_scan_key),
        .i_scan_code (w_nxt_code),
        .o_key_code  (o_key_code),
        .o_key_valid (o_key_valid),
        .o_key_down  (o_key_down),
        .o_key_hist  (o_key_hist)
    );

endmodule
